// File: rtl/rmw_sequencer.sv
// rmw_sequencer: NMOS-6502-style read-modify-write controller.
// Reads the operand, dummy-writes the original value, writes the ALU
// result, then pulses DONE/FLAG_WE with the ALU-produced flags.
module rmw_sequencer #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned MAX_WAIT       = 15,
    // ALU control encodings; defaults must track the shared ALU's params.vh
    parameter logic [3:0]  C_ALU_CTRL_THA = 4'h0,
    parameter logic [3:0]  C_ALU_CTRL_INC = 4'h1,
    parameter logic [3:0]  C_ALU_CTRL_DEC = 4'h2,
    parameter logic [3:0]  C_ALU_CTRL_ASL = 4'h3,
    parameter logic [3:0]  C_ALU_CTRL_LSR = 4'h4,
    parameter logic [3:0]  C_ALU_CTRL_ROL = 4'h5,
    parameter logic [3:0]  C_ALU_CTRL_ROR = 4'h6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [2:0]        OP,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [7:0]        FLAG_IN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_WDATA,
    output logic              MEM_WE,
    output logic              MEM_REQ,
    input  logic [7:0]        MEM_RDATA,
    input  logic              MEM_RDY,
    output logic [7:0]        ALU_A,
    output logic [7:0]        ALU_B,
    output logic [3:0]        ALU_CTRL,
    output logic [7:0]        ALU_FLAG,
    input  logic [7:0]        ALU_OUT,
    input  logic [7:0]        ALU_FLAG_OUT,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              FLAG_WE,
    output logic [7:0]        FLAG_OUT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DUMMY,
        S_WRITE,
        S_FIN
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        op_q, op_d;
    logic [7:0]        flag_in_q, flag_in_d;
    logic [7:0]        operand_q, operand_d;
    logic [7:0]        result_q, result_d;
    logic [7:0]        flags_q, flags_d;
    logic [7:0]        wait_q, wait_d;
    logic              err_q, err_d;
    logic              timeout;
    logic              bus_state;

    // Next-state, datapath capture and output decode
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        op_d      = op_q;
        flag_in_d = flag_in_q;
        operand_d = operand_q;
        result_d  = result_q;
        flags_d   = flags_q;
        err_d     = 1'b0;
        timeout   = 1'b0;
        bus_state = 1'b0;
        MEM_REQ   = 1'b0;
        MEM_WE    = 1'b0;
        MEM_WDATA = '0;
        DONE      = 1'b0;
        FLAG_WE   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (OP <= 3'd5) begin
                        addr_d    = ADDR;
                        op_d      = OP;
                        flag_in_d = FLAG_IN;
                        state_d   = S_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                bus_state = 1'b1;
                MEM_REQ   = 1'b1;
                if (MEM_RDY) begin
                    operand_d = MEM_RDATA;
                    state_d   = S_DUMMY;
                end
            end
            S_DUMMY: begin
                bus_state = 1'b1;
                MEM_REQ   = 1'b1;
                MEM_WE    = 1'b1;
                MEM_WDATA = operand_q;
                if (MEM_RDY) begin
                    result_d = ALU_OUT;
                    flags_d  = ALU_FLAG_OUT;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                bus_state = 1'b1;
                MEM_REQ   = 1'b1;
                MEM_WE    = 1'b1;
                MEM_WDATA = result_q;
                if (MEM_RDY) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                DONE    = 1'b1;
                FLAG_WE = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Completion in the limit cycle wins, so timeout only fires with RDY low
        if (bus_state && !MEM_RDY && (wait_q == WAIT_LIMIT)) begin
            timeout = 1'b1;
            state_d = S_IDLE;
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (bus_state && !MEM_RDY && (wait_q != 8'hFF)) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    // ALU control decode from the latched opcode; pass-through when idle
    always_comb begin
        ALU_CTRL = C_ALU_CTRL_THA;
        if (state_q != S_IDLE) begin
            case (op_q)
                3'd0:    ALU_CTRL = C_ALU_CTRL_INC;
                3'd1:    ALU_CTRL = C_ALU_CTRL_DEC;
                3'd2:    ALU_CTRL = C_ALU_CTRL_ASL;
                3'd3:    ALU_CTRL = C_ALU_CTRL_LSR;
                3'd4:    ALU_CTRL = C_ALU_CTRL_ROL;
                3'd5:    ALU_CTRL = C_ALU_CTRL_ROR;
                default: ALU_CTRL = C_ALU_CTRL_THA;
            endcase
        end
    end

    assign MEM_ADDR = addr_q;
    assign ALU_A    = operand_q;
    assign ALU_B    = '0;
    assign ALU_FLAG = flag_in_q;
    assign BUSY     = (state_q != S_IDLE);
    assign ERR      = err_q | timeout;
    assign FLAG_OUT = flags_q;

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            op_q      <= '0;
            flag_in_q <= '0;
            operand_q <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            wait_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            flag_in_q <= flag_in_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_rmw_sequencer.sv
// tb_rmw_sequencer: scoreboard bench for rmw_sequencer with a behavioural
// ALU and byte-wide memory model.
`timescale 1ns/1ps
module tb_rmw_sequencer;

    localparam logic [3:0] C_THA = 4'h0;
    localparam logic [3:0] C_INC = 4'h1;
    localparam logic [3:0] C_DEC = 4'h2;
    localparam logic [3:0] C_ASL = 4'h3;
    localparam logic [3:0] C_LSR = 4'h4;
    localparam logic [3:0] C_ROL = 4'h5;
    localparam logic [3:0] C_ROR = 4'h6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [15:0] addr = '0;
    logic [7:0]  flag_in = '0;
    logic        mem_rdy = 1'b1;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, mem_req;
    logic [7:0]  alu_a, alu_b, alu_flag, alu_out, alu_flag_out;
    logic [3:0]  alu_ctrl;
    logic [2:0]  alu_op;
    logic        busy, done, err, flag_we;
    logic [7:0]  flag_out;

    logic [7:0]  mem [0:65535];

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_t;

    bus_t        exp_q[$];
    logic [7:0]  flag_q[$];
    bus_t        mon_e;
    logic [7:0]  mon_d, mon_f;

    int checks = 0;
    int errors = 0;

    // per-run observations recorded by run_op
    int          done_c, done_last, done_n, err_c, err_n, fwe_n, req_n, addr_bad;
    logic [31:0] busy_v, req_v, we_v;
    logic [7:0]  wd_v [0:31];
    logic [7:0]  fo_v [0:31];
    logic [2:0]  g_op;
    logic [15:0] g_addr;
    logic [7:0]  g_flag;

    always #5 clk = ~clk;

    rmw_sequencer #(
        .ADDR_W(16), .MAX_WAIT(15),
        .C_ALU_CTRL_THA(C_THA), .C_ALU_CTRL_INC(C_INC), .C_ALU_CTRL_DEC(C_DEC),
        .C_ALU_CTRL_ASL(C_ASL), .C_ALU_CTRL_LSR(C_LSR), .C_ALU_CTRL_ROL(C_ROL),
        .C_ALU_CTRL_ROR(C_ROR)
    ) dut (
        .CLK(clk), .RST(rst), .START(start), .OP(op), .ADDR(addr), .FLAG_IN(flag_in),
        .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_WE(mem_we), .MEM_REQ(mem_req),
        .MEM_RDATA(mem_rdata), .MEM_RDY(mem_rdy),
        .ALU_A(alu_a), .ALU_B(alu_b), .ALU_CTRL(alu_ctrl), .ALU_FLAG(alu_flag),
        .ALU_OUT(alu_out), .ALU_FLAG_OUT(alu_flag_out),
        .BUSY(busy), .DONE(done), .ERR(err), .FLAG_WE(flag_we), .FLAG_OUT(flag_out)
    );

    // 6502 RMW semantics: returns {result, flags}
    function automatic logic [15:0] ref_alu(input logic [2:0] o, input logic [7:0] a, input logic [7:0] f);
        logic [7:0] r;
        logic [7:0] nf;
        logic       c;
        c = f[0];
        case (o)
            3'd0: r = a + 8'd1;
            3'd1: r = a - 8'd1;
            3'd2: begin r = {a[6:0], 1'b0}; c = a[7]; end
            3'd3: begin r = {1'b0, a[7:1]}; c = a[0]; end
            3'd4: begin r = {a[6:0], f[0]}; c = a[7]; end
            3'd5: begin r = {f[0], a[7:1]}; c = a[0]; end
            default: return {a, f};
        endcase
        nf    = f;
        nf[7] = r[7];
        nf[1] = (r == 8'h00);
        nf[0] = c;
        return {r, nf};
    endfunction

    // Behavioural shared ALU
    always_comb begin
        case (alu_ctrl)
            C_INC:   alu_op = 3'd0;
            C_DEC:   alu_op = 3'd1;
            C_ASL:   alu_op = 3'd2;
            C_LSR:   alu_op = 3'd3;
            C_ROL:   alu_op = 3'd4;
            C_ROR:   alu_op = 3'd5;
            default: alu_op = 3'd7;
        endcase
        {alu_out, alu_flag_out} = ref_alu(alu_op, alu_a, alu_flag);
    end

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!rst && mem_req && mem_we && mem_rdy) mem[mem_addr] <= mem_wdata;
    end

    // Scoreboard: completed bus cycles and flag commits
    always @(negedge clk) begin
        if (!rst && mem_req && mem_rdy) begin
            checks++;
            mon_d = mem_we ? mem_wdata : mem_rdata;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_extra: got we=%0b addr=%h data=%h, expected no bus cycle", mem_we, mem_addr, mon_d);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_we !== mon_e.we || mem_addr !== mon_e.addr || mon_d !== mon_e.data) begin
                    errors++;
                    $display("FAIL bus_cycle: got we=%0b addr=%h data=%h, expected we=%0b addr=%h data=%h",
                             mem_we, mem_addr, mon_d, mon_e.we, mon_e.addr, mon_e.data);
                end
            end
        end
        if (!rst && done) begin
            checks++;
            if (flag_q.size() == 0) begin
                errors++;
                $display("FAIL done_extra: got DONE with FLAG_OUT=%h, expected no completion", flag_out);
            end else begin
                mon_f = flag_q.pop_front();
                if (flag_out !== mon_f) begin
                    errors++;
                    $display("FAIL flag_out: got %h expected %h", flag_out, mon_f);
                end
            end
        end
        if (!rst && (done || flag_we)) begin
            checks++;
            if (flag_we !== done) begin
                errors++;
                $display("FAIL flag_we_done: got FLAG_WE=%0b DONE=%0b, expected equal", flag_we, done);
            end
        end
    end

    task automatic push_op(input logic [2:0] o, input logic [15:0] a, input logic [7:0] m, input logic [7:0] f);
        logic [15:0] rf;
        rf = ref_alu(o, m, f);
        mem[a] = m;
        exp_q.push_back('{we: 1'b0, addr: a, data: m});
        exp_q.push_back('{we: 1'b1, addr: a, data: m});
        exp_q.push_back('{we: 1'b1, addr: a, data: rf[15:8]});
        flag_q.push_back(rf[7:0]);
    endtask

    // Drives one START at cycle 0 (plus an optional second START at ghost_c),
    // MEM_RDY from pat, RST at rst_c, and records what the DUT did.
    task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [7:0] f,
                          input logic [31:0] pat, input int ncyc, input int rst_c, input int ghost_c);
        @(posedge clk); #1;
        done_c = -1; done_last = -1; done_n = 0; err_c = -1; err_n = 0;
        fwe_n = 0; req_n = 0; addr_bad = 0; busy_v = '0; req_v = '0; we_v = '0;
        for (int c = 0; c < ncyc; c++) begin
            start   = (c == 0) || (c == ghost_c);
            op      = (c == 0) ? o : g_op;
            addr    = (c == 0) ? a : g_addr;
            flag_in = (c == 0) ? f : g_flag;
            rst     = (c == rst_c);
            mem_rdy = pat[c];
            @(negedge clk);
            if (done) begin
                if (done_c < 0) done_c = c;
                done_last = c;
                done_n++;
            end
            if (err) begin
                if (err_c < 0) err_c = c;
                err_n++;
            end
            if (flag_we) fwe_n++;
            if (mem_req) begin
                req_n++;
                if (mem_addr !== a) addr_bad++;
            end
            busy_v[c] = busy;
            req_v[c]  = mem_req;
            we_v[c]   = mem_we;
            wd_v[c]   = mem_wdata;
            fo_v[c]   = flag_out;
            @(posedge clk); #1;
        end
        start = 1'b0; rst = 1'b0; mem_rdy = 1'b1;
        g_op = 3'd1; g_addr = 16'hBEEF; g_flag = 8'hFF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_bus: got req=%0b we=%0b expected 0 0", mem_req, mem_we); end
        checks++; if (done !== 1'b0 || err !== 1'b0 || flag_we !== 1'b0) begin errors++; $display("FAIL rst_pulses: got done=%0b err=%0b fwe=%0b expected 0", done, err, flag_we); end
        checks++; if (alu_ctrl !== C_THA) begin errors++; $display("FAIL rst_alu_ctrl: got %h expected %h", alu_ctrl, C_THA); end
        checks++; if (mem_addr !== 16'h0 || mem_wdata !== 8'h0 || flag_out !== 8'h0) begin errors++; $display("FAIL rst_data: got addr=%h wdata=%h flags=%h expected 0", mem_addr, mem_wdata, flag_out); end
        checks++; if (alu_a !== 8'h0 || alu_b !== 8'h0 || alu_flag !== 8'h0) begin errors++; $display("FAIL rst_alu_in: got a=%h b=%h f=%h expected 0", alu_a, alu_b, alu_flag); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_inc();
        push_op(3'd0, 16'h0200, 8'hFF, 8'h00);
        run_op(3'd0, 16'h0200, 8'h00, '1, 8, 99, 0);
        checks++; if (done_c !== 4 || done_n !== 1) begin errors++; $display("FAIL inc_latency: got done at %0d (n=%0d) expected 4 (n=1)", done_c, done_n); end
        checks++; if (busy_v[5:0] !== 6'b011110) begin errors++; $display("FAIL inc_busy: got %b expected 011110", busy_v[5:0]); end
        checks++; if (addr_bad !== 0) begin errors++; $display("FAIL inc_addr: got %0d bad cycles expected 0", addr_bad); end
        checks++; if (mem[16'h0200] !== 8'h00) begin errors++; $display("FAIL inc_mem: got %h expected 00", mem[16'h0200]); end
        checks++; if (fo_v[6] !== 8'h02) begin errors++; $display("FAIL inc_flag_hold: got %h expected 02", fo_v[6]); end
    endtask

    task automatic test_ror();
        push_op(3'd5, 16'h0204, 8'h01, 8'h01);
        run_op(3'd5, 16'h0204, 8'h01, '1, 7, 99, 0);
        checks++; if (done_c !== 4) begin errors++; $display("FAIL ror_latency: got %0d expected 4", done_c); end
        checks++; if (mem[16'h0204] !== 8'h80) begin errors++; $display("FAIL ror_mem: got %h expected 80", mem[16'h0204]); end
    endtask

    task automatic test_back_to_back();
        push_op(3'd1, 16'h0208, 8'h00, 8'h40);
        push_op(3'd2, 16'h0210, 8'h81, 8'h00);
        g_op = 3'd2; g_addr = 16'h0210; g_flag = 8'h00;
        run_op(3'd1, 16'h0208, 8'h40, '1, 12, 99, 5);
        checks++; if (done_n !== 2 || done_c !== 4 || done_last !== 9) begin errors++; $display("FAIL b2b_done: got n=%0d first=%0d last=%0d expected 2 4 9", done_n, done_c, done_last); end
        checks++; if (busy_v[6:5] !== 2'b10) begin errors++; $display("FAIL b2b_busy: got %b expected 10", busy_v[6:5]); end
        checks++; if (mem[16'h0208] !== 8'hFF || mem[16'h0210] !== 8'h02) begin errors++; $display("FAIL b2b_mem: got %h %h expected ff 02", mem[16'h0208], mem[16'h0210]); end
    endtask

    task automatic test_wait_states();
        push_op(3'd0, 16'h0220, 8'h7F, 8'h00);
        run_op(3'd0, 16'h0220, 8'h00, ~32'h0000_00CE, 14, 99, 5);
        checks++; if (done_c !== 9 || done_n !== 1) begin errors++; $display("FAIL wait_latency: got %0d (n=%0d) expected 9 (n=1)", done_c, done_n); end
        checks++; if (req_n !== 8 || addr_bad !== 0) begin errors++; $display("FAIL wait_req: got req=%0d bad=%0d expected 8 0", req_n, addr_bad); end
        checks++; if (wd_v[5] !== 8'h7F || wd_v[6] !== 8'h80 || wd_v[7] !== 8'h80 || wd_v[8] !== 8'h80) begin
            errors++; $display("FAIL wait_wdata: got %h %h %h %h expected 7f 80 80 80", wd_v[5], wd_v[6], wd_v[7], wd_v[8]);
        end
        checks++; if (busy_v[13:10] !== 4'b0000) begin errors++; $display("FAIL wait_ignored_start: got busy %b expected 0000", busy_v[13:10]); end
    endtask

    task automatic test_timeout();
        mem[16'h0230] = 8'h10;
        exp_q.push_back('{we: 1'b0, addr: 16'h0230, data: 8'h10});
        run_op(3'd0, 16'h0230, 8'h00, 32'h0000_0003, 24, 99, 0);
        checks++; if (err_c !== 17 || err_n !== 1) begin errors++; $display("FAIL timeout_err: got at %0d (n=%0d) expected 17 (n=1)", err_c, err_n); end
        checks++; if (busy_v[18:17] !== 2'b01 || req_v[18] !== 1'b0 || we_v[18] !== 1'b0) begin
            errors++; $display("FAIL timeout_idle: got busy=%b req=%0b we=%0b expected 01 0 0", busy_v[18:17], req_v[18], we_v[18]);
        end
        checks++; if (done_n !== 0 || fwe_n !== 0) begin errors++; $display("FAIL timeout_nodone: got done=%0d fwe=%0d expected 0 0", done_n, fwe_n); end
        checks++; if (mem[16'h0230] !== 8'h10) begin errors++; $display("FAIL timeout_mem: got %h expected 10", mem[16'h0230]); end
    endtask

    task automatic test_wait_limit();
        push_op(3'd4, 16'h0240, 8'h41, 8'h01);
        run_op(3'd4, 16'h0240, 8'h01, ~32'h0001_FFFC, 22, 99, 0);
        checks++; if (done_c !== 19 || err_n !== 0) begin errors++; $display("FAIL limit_done: got done=%0d err=%0d expected 19 0", done_c, err_n); end
        checks++; if (mem[16'h0240] !== 8'h83) begin errors++; $display("FAIL limit_mem: got %h expected 83", mem[16'h0240]); end
    endtask

    task automatic test_illegal_op();
        run_op(3'd7, 16'h0250, 8'h00, '1, 6, 99, 0);
        checks++; if (err_c !== 1 || err_n !== 1) begin errors++; $display("FAIL illegal_err: got at %0d (n=%0d) expected 1 (n=1)", err_c, err_n); end
        checks++; if (req_n !== 0 || busy_v[5:0] !== 6'b0 || done_n !== 0) begin errors++; $display("FAIL illegal_quiet: got req=%0d busy=%b done=%0d expected 0", req_n, busy_v[5:0], done_n); end
    endtask

    task automatic test_reset_mid_write();
        mem[16'h0260] = 8'h33;
        exp_q.push_back('{we: 1'b0, addr: 16'h0260, data: 8'h33});
        exp_q.push_back('{we: 1'b1, addr: 16'h0260, data: 8'h33});
        run_op(3'd0, 16'h0260, 8'h00, ~32'h0000_0008, 10, 3, 0);
        checks++; if (busy_v[4] !== 1'b0 || req_v[4] !== 1'b0 || we_v[4] !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: got busy=%0b req=%0b we=%0b expected 0 0 0", busy_v[4], req_v[4], we_v[4]);
        end
        checks++; if (done_n !== 0 || fwe_n !== 0) begin errors++; $display("FAIL rstmid_nodone: got done=%0d fwe=%0d expected 0 0", done_n, fwe_n); end
        push_op(3'd0, 16'h0260, 8'h33, 8'h00);
        run_op(3'd0, 16'h0260, 8'h00, '1, 7, 99, 0);
        checks++; if (done_c !== 4 || mem[16'h0260] !== 8'h34) begin errors++; $display("FAIL rstmid_fresh: got done=%0d mem=%h expected 4 34", done_c, mem[16'h0260]); end
    endtask

    task automatic test_random_ops();
        logic [2:0]  o;
        logic [7:0]  m, f;
        logic [15:0] rf;
        for (int i = 0; i < 8; i++) begin
            o  = 3'($urandom_range(5, 0));
            m  = 8'($urandom);
            f  = 8'($urandom);
            rf = ref_alu(o, m, f);
            push_op(o, 16'h0300 + 16'(i), m, f);
            run_op(o, 16'h0300 + 16'(i), f, '1, 6, 99, 0);
            checks++; if (done_c !== 4 || mem[16'h0300 + 16'(i)] !== rf[15:8]) begin
                errors++; $display("FAIL random_op%0d: got done=%0d mem=%h expected 4 %h", o, done_c, mem[16'h0300 + 16'(i)], rf[15:8]);
            end
        end
    endtask

    task automatic test_drain();
        repeat (2) @(posedge clk);
        checks++; if (exp_q.size() != 0 || flag_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d bus %0d flag entries left expected 0 0", exp_q.size(), flag_q.size());
        end
    endtask

    initial begin
        g_op = 3'd1; g_addr = 16'hBEEF; g_flag = 8'hFF;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset();
        test_inc();
        test_ror();
        test_back_to_back();
        test_wait_states();
        test_timeout();
        test_wait_limit();
        test_illegal_op();
        test_reset_mid_write();
        test_random_ops();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1);
    end

endmodule
